// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding,
// default watchdog limit and counter-width helpers.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    APBM_IDLE   = 2'd0,
    APBM_SETUP  = 2'd1,
    APBM_ACCESS = 2'd2,
    APBM_RESP   = 2'd3
  } apbm_state_e;

  localparam int unsigned DEF_APB_TIMEOUT = 255;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result++;
    end
    return result;
  endfunction

  // Width of a counter holding 0..limit; never narrower than one bit.
  function automatic int unsigned tmo_cnt_width(input int unsigned limit);
    int unsigned w;
    w = clog2(limit + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding core request to APB master transfer (SETUP/ACCESS),
// with a watchdog that aborts an ACCESS phase stuck on PREADY low.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = DEF_APB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [BUS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [BUS_WIDTH-1:0]  M_PADDR,
  output logic                  M_PWRITE,
  output logic                  M_PSELx,
  output logic                  M_PENABLE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PREADY
);

  localparam int unsigned     CW       = tmo_cnt_width(TIMEOUT);
  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0]   TMO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apbm_state_e           r_state;
  logic [CW-1:0]         r_tmo_cnt;
  logic [BUS_WIDTH-1:0]  r_paddr;
  logic                  r_pwrite;
  logic                  r_psel;
  logic                  r_penable;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic                  r_resp_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= APBM_IDLE;
      r_tmo_cnt    <= '0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwdata     <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        APBM_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (req_valid) begin
            r_paddr   <= req_addr;
            r_pwrite  <= req_write;
            r_pwdata  <= req_wdata;
            r_psel    <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= APBM_SETUP;
          end
        end
        APBM_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= APBM_ACCESS;
        end
        APBM_ACCESS: begin
          if (M_PREADY) begin
            r_resp_rdata <= r_pwrite ? '0 : M_PRDATA;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_state      <= APBM_RESP;
          end else if (TMO_EN && (r_tmo_cnt == TMO_LAST)) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_state      <= APBM_RESP;
          end else if (r_tmo_cnt != '1) begin
            // Saturates so a disabled watchdog can never wrap into a false match.
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        APBM_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_state      <= APBM_IDLE;
        end
        default: r_state <= APBM_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == APBM_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign M_PADDR    = r_paddr;
  assign M_PWRITE   = r_pwrite;
  assign M_PSELx    = r_psel;
  assign M_PENABLE  = r_penable;
  assign M_PWDATA   = r_pwdata;

  a_enable_implies_sel: assert property (
    @(posedge clk) disable iff (!reset) r_penable |-> r_psel);

  a_access_stable: assert property (
    @(posedge clk) disable iff (!reset)
    (r_psel && r_penable) |=> ($stable(r_paddr) && $stable(r_pwrite) && $stable(r_pwdata)));

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench: three bridges (two at TIMEOUT=255, one at TIMEOUT=4) sharing
// an arbitrated behavioural APB slave, checked against a memory-level reference.
module tb_apb_master_bridge;

  localparam int NM = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        req_valid  [NM];
  logic        req_write  [NM];
  logic [15:0] req_addr   [NM];
  logic [15:0] req_wdata  [NM];
  logic        req_ready  [NM];
  logic        resp_valid [NM];
  logic [15:0] resp_rdata [NM];
  logic        resp_err   [NM];
  logic [15:0] paddr      [NM];
  logic        pwrite     [NM];
  logic        psel       [NM];
  logic        penable    [NM];
  logic [15:0] pwdata     [NM];
  logic [15:0] prdata     [NM];
  logic        pready     [NM];

  logic [15:0] init_mem [256];
  logic [15:0] slv_mem  [256];
  logic [15:0] ref_mem  [256];
  bit          loaded = 1'b0;
  int          wait_cfg [NM];
  int          wcnt     [NM];
  int          gnt = -1;
  int          rr  = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NM; g++) begin : g_br
    apb_master_bridge #(
      .BUS_WIDTH (16),
      .DATA_WIDTH(16),
      .TIMEOUT   ((g == 2) ? 4 : 255)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .req_valid (req_valid[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g]),
      .M_PADDR   (paddr[g]),
      .M_PWRITE  (pwrite[g]),
      .M_PSELx   (psel[g]),
      .M_PENABLE (penable[g]),
      .M_PWDATA  (pwdata[g]),
      .M_PRDATA  (prdata[g]),
      .M_PREADY  (pready[g])
    );
  end

  // Interconnect + slave: only the granted master sees PREADY; grant moves on when its PSEL drops.
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      pready[m] = (gnt == m) && psel[m] && penable[m] && (wcnt[m] == 0);
      prdata[m] = slv_mem[paddr[m][7:0]];
    end
  end

  always @(posedge clk) begin : slave_seq
    int pick;
    if (!loaded) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= init_mem[i];
      loaded <= 1'b1;
    end
    for (int m = 0; m < NM; m++) begin
      if (psel[m] && !penable[m]) wcnt[m] <= wait_cfg[m];
      else if ((gnt == m) && psel[m] && penable[m] && (wcnt[m] > 0)) wcnt[m] <= wcnt[m] - 1;
      if (pready[m] && pwrite[m]) slv_mem[paddr[m][7:0]] <= pwdata[m];
    end
    if ((gnt < 0) || !psel[gnt]) begin
      pick = -1;
      for (int k = NM - 1; k >= 0; k--) if (psel[(rr + k) % NM]) pick = (rr + k) % NM;
      gnt <= pick;
      if (pick >= 0) rr <= (pick + 1) % NM;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int m, input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[m] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready[m]), 32'd1);
    req_valid[m] = 1'b1;
    req_write[m] = wr;
    req_addr[m]  = addr;
    req_wdata[m] = wdata;
    @(posedge clk);
    #1;
    req_valid[m] = 1'b0;
    req_write[m] = 1'($urandom);
    req_addr[m]  = 16'($urandom);
    req_wdata[m] = 16'($urandom);
  endtask

  task automatic do_xfer(input int m, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int waits, input bit exact);
    int          t;
    int          acc_exp;
    bit          err_exp;
    logic [15:0] rd_exp;
    int          psel_n;
    int          pen_n;
    bit          stable_ok;
    bit          ready_ok;
    bit          got;
    t         = (m == 2) ? 4 : 255;
    err_exp   = (waits >= t);
    acc_exp   = err_exp ? t : waits + 1;
    rd_exp    = (err_exp || wr) ? 16'h0 : ref_mem[addr[7:0]];
    psel_n    = 0;
    pen_n     = 0;
    stable_ok = 1'b1;
    ready_ok  = 1'b1;
    got       = 1'b0;
    wait_cfg[m] = waits;
    issue(m, wr, addr, wdata);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (resp_valid[m]) begin
        got = 1'b1;
        break;
      end
      if (psel[m]) psel_n++;
      if (penable[m]) pen_n++;
      if (paddr[m] !== addr || pwrite[m] !== wr || pwdata[m] !== wdata || psel[m] !== 1'b1)
        stable_ok = 1'b0;
      if (req_ready[m]) ready_ok = 1'b0;
    end
    chk("resp_seen", 32'(got), 32'd1);
    if (got) begin
      chk("resp_err", 32'(resp_err[m]), 32'(err_exp));
      chk("resp_rdata", 32'(resp_rdata[m]), 32'(rd_exp));
      chk("bus_idle_in_resp", 32'({psel[m], penable[m]}), 32'd0);
      chk("ctrl_stable", 32'(stable_ok), 32'd1);
      chk("ready_low_busy", 32'(ready_ok), 32'd1);
      if (exact) begin
        chk("psel_cycles", psel_n, acc_exp + 1);
        chk("penable_cycles", pen_n, acc_exp);
      end
      @(negedge clk);
      chk("resp_pulse", 32'(resp_valid[m]), 32'd0);
      chk("err_clear", 32'(resp_err[m]), 32'd0);
      chk("rdata_hold", 32'(resp_rdata[m]), 32'(rd_exp));
      chk("ready_after", 32'(req_ready[m]), 32'd1);
      if (wr && !err_exp) ref_mem[addr[7:0]] = wdata;
    end
  endtask

  task automatic b2b();
    logic [15:0] a [3];
    int          acc [3];
    int          nacc;
    int          nresp;
    bit          prev_psel;
    bit          seen;
    int          low_run;
    bit          rdy_ok;
    nacc = 0; nresp = 0; prev_psel = 1'b0; seen = 1'b0; low_run = 0; rdy_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[i]   = 16'($urandom);
      acc[i] = 0;
    end
    wait_cfg[0] = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (resp_valid[0] && nresp < 3) begin
        chk("b2b_rdata", 32'(resp_rdata[0]), 32'(ref_mem[a[nresp][7:0]]));
        chk("b2b_err", 32'(resp_err[0]), 32'd0);
        nresp++;
      end
      if (req_ready[0] !== (!psel[0] && !resp_valid[0])) rdy_ok = 1'b0;
      if (psel[0]) begin
        if (seen && !prev_psel) chk("b2b_psel_gap", low_run, 2);
        seen    = 1'b1;
        low_run = 0;
      end else if (seen) begin
        low_run++;
      end
      prev_psel    = psel[0];
      req_valid[0] = (nacc < 3);
      req_write[0] = 1'b0;
      req_addr[0]  = a[(nacc < 3) ? nacc : 2];
      if (req_ready[0] && nacc < 3) begin
        acc[nacc] = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_resps", nresp, 3);
    chk("b2b_gap01", acc[1] - acc[0], 4);
    chk("b2b_gap12", acc[2] - acc[1], 4);
    chk("b2b_ready_idle_only", 32'(rdy_ok), 32'd1);
  endtask

  initial begin : main
    int          m;
    int          w;
    bit          wr;
    logic [15:0] ad;
    bit          stale;
    for (int i = 0; i < NM; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      wait_cfg[i]  = 0;
      wcnt[i]      = 0;
    end
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = 16'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    init_mem[8'h20] = 16'h1234;
    ref_mem[8'h20]  = 16'h1234;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      chk("rst_psel", 32'(psel[i]), 32'd0);
      chk("rst_penable", 32'(penable[i]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
    end
    chk("rst_paddr", 32'(paddr[0]), 32'd0);
    chk("rst_pwdata", 32'(pwdata[0]), 32'd0);
    chk("rst_rdata", 32'(resp_rdata[0]), 32'd0);
    chk("rst_err", 32'(resp_err[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_post_rst", 32'(req_ready[0]), 32'd1);

    do_xfer(0, 1'b1, 16'h0010, 16'hBEEF, 0, 1'b1);
    do_xfer(0, 1'b0, 16'h0020, 16'h0000, 3, 1'b1);
    do_xfer(2, 1'b0, 16'h0030, 16'h0000, 100000, 1'b1);
    do_xfer(2, 1'b1, 16'h0031, 16'h5A5A, 0, 1'b1);
    do_xfer(2, 1'b0, 16'h0031, 16'h0000, 3, 1'b1);
    do_xfer(2, 1'b1, 16'h0032, 16'hC3C3, 4, 1'b1);
    do_xfer(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b1);

    b2b();

    repeat (24) begin
      m  = $urandom_range(0, 2);
      w  = (m == 2) ? $urandom_range(0, 5) : $urandom_range(0, 4);
      wr = 1'($urandom);
      do_xfer(m, wr, 16'($urandom), 16'($urandom), w, 1'b1);
    end

    repeat (6) begin
      ad = 16'($urandom);
      fork
        do_xfer(0, 1'($urandom), ad, 16'($urandom), $urandom_range(0, 3), 1'b0);
        do_xfer(1, 1'($urandom), ad ^ 16'h0080, 16'($urandom), $urandom_range(0, 3), 1'b0);
      join
    end

    wait_cfg[2] = 100000;
    issue(2, 1'b0, 16'h0040, 16'h0000);
    for (int n = 0; n < 10 && !penable[2]; n++) @(negedge clk);
    chk("rst_mid_pen_reached", 32'(penable[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_psel", 32'(psel[2]), 32'd0);
    chk("async_rst_penable", 32'(penable[2]), 32'd0);
    chk("async_rst_resp_valid", 32'(resp_valid[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_mid_rst", 32'(req_ready[2]), 32'd1);
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[2] || psel[2]) stale = 1'b1;
    end
    chk("no_stale_resp", 32'(stale), 32'd0);
    do_xfer(2, 1'b0, 16'h0041, 16'h0000, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
